// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter slice
//   state_t : arbiter FSM states (IDLE, BUSY)
//   BYTE_W  : width of one UART byte lane
package uart_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: AXI-stream bundle between NUM_SRC requesters, the arbiter and uart_tx
//   s_axis_tvalid/tdata/tlast/tready : per-source request side, source i at tdata[8i+7:8i]
//   m_axis_tvalid/tdata/tlast/tready : single byte stream toward uart_tx
//   master : requesters + uart_tx side, slave : the arbiter
interface uart_tx_arbiter_if #(
   parameter int NUM_SRC = 4
);
   import uart_pkg::*;
   logic [NUM_SRC-1:0]        s_axis_tvalid;
   logic [NUM_SRC*BYTE_W-1:0] s_axis_tdata;
   logic [NUM_SRC-1:0]        s_axis_tlast;
   logic [NUM_SRC-1:0]        s_axis_tready;
   logic                      m_axis_tvalid;
   logic [BYTE_W-1:0]         m_axis_tdata;
   logic                      m_axis_tlast;
   logic                      m_axis_tready;
   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );
   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester searched cyclically from last+1
//   req    : request vector
//   last   : index granted most recently
//   winner : chosen index (don't-care when any is low)
//   any    : at least one request present
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] winner,
   output logic         any
);
   logic [W-1:0] idx;
   always_comb begin
      winner = last;
      idx = '0;
      // scan from the farthest candidate back to last+1 so the nearest requester is written last
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(last) + k) % N);
         if (req[idx]) winner = idx;
      end
      any = |req;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx byte stream
//   aclk, aresetn : clock, synchronous active-low reset (shared with uart_tx)
//   bus           : slave side of uart_tx_arbiter_if (requesters in, uart_tx out)
//   grant_valid   : a source currently holds the grant
//   grant_id      : current or most recent grant index
//   timeout_pulse : one cycle when a stalled grant is revoked
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int          NUM_SRC      = 4,
   parameter  int unsigned IDLE_TIMEOUT = 1_250_000,
   localparam int          SRC_ID_W     = $clog2(NUM_SRC)
) (
   input  logic                aclk,
   input  logic                aresetn,
   uart_tx_arbiter_if.slave    bus,
   output logic                grant_valid,
   output logic [SRC_ID_W-1:0] grant_id,
   output logic                timeout_pulse
);
   state_t              state, state_n;
   logic [SRC_ID_W-1:0] last_grant, winner;
   logic [BYTE_W-1:0]   g_data;
   logic [31:0]         idle_cnt;
   logic                any_req, g_valid, g_last, can_load, accept, expire, pkt_end;

   rr_arbiter #(.N(NUM_SRC), .W(SRC_ID_W)) u_rr (
      .req    (bus.s_axis_tvalid),
      .last   (last_grant),
      .winner (winner),
      .any    (any_req)
   );

   assign g_valid  = bus.s_axis_tvalid[grant_id];
   assign g_last   = bus.s_axis_tlast[grant_id];
   assign g_data   = BYTE_W'(bus.s_axis_tdata >> (grant_id * BYTE_W));
   // the single output register may take a new beat when empty or draining this cycle
   assign can_load = !bus.m_axis_tvalid || bus.m_axis_tready;
   assign accept   = (state == BUSY) && g_valid && can_load;
   assign pkt_end  = accept && g_last;
   // an accept in the expiry cycle wins because expire requires the granted tvalid low
   assign expire   = (state == BUSY) && !g_valid && (IDLE_TIMEOUT != 0) && (idle_cnt == IDLE_TIMEOUT - 1);
   assign bus.s_axis_tready = (state == BUSY && can_load) ? (NUM_SRC'(1) << grant_id) : '0;

   always_ff @(posedge aclk) state <= !aresetn ? IDLE : state_n;

   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (any_req ? BUSY : IDLE) : ((pkt_end || expire) ? IDLE : BUSY);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         bus.m_axis_tvalid <= 1'b0;
         bus.m_axis_tdata  <= '0;
         bus.m_axis_tlast  <= 1'b0;
         grant_valid       <= 1'b0;
         grant_id          <= '0;
         timeout_pulse     <= 1'b0;
         last_grant        <= SRC_ID_W'(NUM_SRC - 1);
         idle_cnt          <= '0;
      end else begin
         timeout_pulse <= expire;
         if (accept) begin
            bus.m_axis_tvalid <= 1'b1;
            bus.m_axis_tdata  <= g_data;
            bus.m_axis_tlast  <= g_last;
         end else if (bus.m_axis_tready) begin
            bus.m_axis_tvalid <= 1'b0;
         end
         if (state == IDLE && any_req) begin
            grant_id    <= winner;
            grant_valid <= 1'b1;
         end
         if (pkt_end || expire) begin
            grant_valid <= 1'b0;
            last_grant  <= grant_id;
         end
         idle_cnt <= (state == IDLE || accept || expire) ? '0
                   : idle_cnt + ((g_valid || IDLE_TIMEOUT == 0) ? 32'd0 : 32'd1);
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter (NUM_SRC=4, IDLE_TIMEOUT=8)
module tb_uart_tx_arbiter;
   import uart_pkg::*;
   localparam int N  = 4;
   localparam int TO = 8;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       grant_valid, timeout_pulse;
   logic [1:0] grant_id;
   int         checks = 0;
   int         errors = 0;

   uart_tx_arbiter_if #(.NUM_SRC(N)) bus ();

   uart_tx_arbiter #(.NUM_SRC(N), .IDLE_TIMEOUT(TO)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .bus           (bus),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .timeout_pulse (timeout_pulse)
   );

   always #5 aclk = ~aclk;

   // per-source beat lists {tlast, byte}; observed output and grants; model expectations
   logic [8:0] srcq [N][$];
   logic [8:0] expq [$];
   logic [8:0] obs [$];
   int         eg [$];
   int         gq [$];
   int         gcyc [$];
   int         ocyc [$];

   typedef struct packed {
      int          src;
      int          len;
      logic [31:0] b;
      int          gid;
      int          lat;
   } vec_t;
   vec_t vt [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic set(input int i, input logic v, input logic [7:0] d, input logic l);
      bus.s_axis_tvalid[i]       = v;
      bus.s_axis_tdata[8*i +: 8] = d;
      bus.s_axis_tlast[i]        = l;
   endtask

   task automatic clear_src();
      for (int i = 0; i < N; i++) srcq[i].delete();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      bus.s_axis_tvalid = '0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = '0;
      bus.m_axis_tready = 1'b1;
      step();
      step();
      aresetn = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mvalid"}, 32'(bus.m_axis_tvalid), 0);
      chk({tag, "_mdata"}, 32'(bus.m_axis_tdata), 0);
      chk({tag, "_mlast"}, 32'(bus.m_axis_tlast), 0);
      chk({tag, "_gvalid"}, 32'(grant_valid), 0);
      chk({tag, "_gid"}, 32'(grant_id), 0);
      chk({tag, "_tpulse"}, 32'(timeout_pulse), 0);
      chk({tag, "_sready"}, 32'(bus.s_axis_tready), 0);
   endtask

   // packet-level round robin: whole packets taken from the next non-empty source after 'last'
   function automatic void build_model(input int last);
      int  p [N];
      int  s;
      bit  found;
      expq.delete();
      eg.delete();
      foreach (p[i]) p[i] = 0;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 1; k <= N && !found; k++) begin
            s = (last + k) % N;
            if (p[s] < srcq[s].size()) begin
               eg.push_back(s);
               do begin
                  expq.push_back(srcq[s][p[s]]);
                  p[s]++;
               end while (!srcq[s][p[s]-1][8]);
               last  = s;
               found = 1'b1;
            end
         end
      end
   endfunction

   // drives every source from srcq, keeps tvalid up until handshake, logs grants and output beats
   task automatic run(input bit rnd, input logic [63:0] rpat, input int budget);
      int         rd [N];
      int         gap [N];
      bit         hs [N];
      logic [8:0] pbeat;
      bit         pstall, pgv, done;
      int         c;
      obs.delete();
      ocyc.delete();
      gq.delete();
      gcyc.delete();
      foreach (rd[i]) begin
         rd[i]  = 0;
         gap[i] = 0;
      end
      pbeat  = '0;
      pstall = 1'b0;
      pgv    = 1'b0;
      done   = 1'b0;
      for (c = 0; c < budget && !done; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rd[i] < srcq[i].size() && gap[i] == 0) set(i, 1'b1, srcq[i][rd[i]][7:0], srcq[i][rd[i]][8]);
            else set(i, 1'b0, 8'h00, 1'b0);
         end
         bus.m_axis_tready = rnd ? ($urandom_range(0, 3) != 0) : (c < 64 ? rpat[c] : 1'b1);
         #1;
         if (pstall) chk("hold", 32'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}), 32'({1'b1, pbeat}));
         chk("s_tready", 32'(bus.s_axis_tready),
             (grant_valid && (!bus.m_axis_tvalid || bus.m_axis_tready)) ? 32'(1) << grant_id : 32'(0));
         if (grant_valid && !pgv) begin
            gq.push_back(int'(grant_id));
            gcyc.push_back(c);
         end
         for (int i = 0; i < N; i++) hs[i] = bus.s_axis_tvalid[i] && bus.s_axis_tready[i];
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            obs.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
            ocyc.push_back(c);
         end
         pstall = bus.m_axis_tvalid && !bus.m_axis_tready;
         pbeat  = {bus.m_axis_tlast, bus.m_axis_tdata};
         pgv    = grant_valid;
         done   = !bus.m_axis_tvalid && !grant_valid;
         for (int i = 0; i < N; i++) if (rd[i] < srcq[i].size()) done = 1'b0;
         if (!done) begin
            step();
            for (int i = 0; i < N; i++) begin
               if (hs[i]) begin
                  gap[i] = (rnd && !srcq[i][rd[i]][8]) ? int'($urandom_range(0, 3)) : 0;
                  rd[i]++;
               end else if (gap[i] > 0) begin
                  gap[i]--;
               end
            end
         end
      end
      chk("drain", 32'(done), 1);
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_nbeats"}, obs.size(), expq.size());
      for (int k = 0; k < obs.size() && k < expq.size(); k++) chk({tag, "_beat"}, 32'(obs[k]), 32'(expq[k]));
      chk({tag, "_ngrants"}, gq.size(), eg.size());
      for (int k = 0; k < gq.size() && k < eg.size(); k++) chk({tag, "_grant"}, gq[k], eg[k]);
   endtask

   initial begin
      int         srcs [3];
      int         ord [6];
      int         bpc [3];
      logic [7:0] byt;
      vt[0] = '{src: 2, len: 3, b: 32'h000A4241, gid: 2, lat: 2};
      vt[1] = '{src: 0, len: 1, b: 32'h0000007E, gid: 0, lat: 2};
      vt[2] = '{src: 3, len: 2, b: 32'h0000BBAA, gid: 3, lat: 2};
      vt[3] = '{src: 1, len: 4, b: 32'h44332211, gid: 1, lat: 2};
      srcs = '{0, 1, 3};
      ord  = '{0, 1, 3, 0, 1, 3};
      bpc  = '{2, 5, 6};

      do_reset();
      #1;
      chk_reset_vals("rst");

      // single-source packets with m_axis_tready held high
      for (int t = 0; t < 4; t++) begin
         clear_src();
         for (int k = 0; k < vt[t].len; k++) srcq[vt[t].src].push_back({k == vt[t].len - 1, vt[t].b[8*k +: 8]});
         run(1'b0, '1, 40);
         chk("tbl_ngrant", gq.size(), 1);
         if (gq.size() == 1) begin
            chk("tbl_gid", gq[0], vt[t].gid);
            chk("tbl_glat", gcyc[0], 1);
         end
         chk("tbl_nbeat", obs.size(), vt[t].len);
         for (int k = 0; k < obs.size() && k < vt[t].len; k++) begin
            byt = vt[t].b[8*k +: 8];
            chk("tbl_beat", 32'(obs[k]), 32'({k == vt[t].len - 1, byt}));
            chk("tbl_bcyc", ocyc[k], vt[t].lat + k);
         end
         chk("tbl_idle", 32'(grant_valid), 0);
      end

      // fairness: sources 0,1,3 each with two 2-byte packets
      do_reset();
      clear_src();
      for (int p = 0; p < 2; p++)
         for (int j = 0; j < 3; j++) begin
            srcq[srcs[j]].push_back({1'b0, 8'(16 * srcs[j] + 2 * p)});
            srcq[srcs[j]].push_back({1'b1, 8'(16 * srcs[j] + 2 * p + 1)});
         end
      build_model(N - 1);
      run(1'b0, '1, 100);
      cmp_model("rr");
      chk("rr_norder", gq.size(), 6);
      for (int k = 0; k < gq.size() && k < 6; k++) chk("rr_order", gq[k], ord[k]);

      // backpressure: m_axis_tready 1,0,0,1 across the packet
      do_reset();
      clear_src();
      srcq[0].push_back({1'b0, 8'h10});
      srcq[0].push_back({1'b0, 8'h11});
      srcq[0].push_back({1'b1, 8'h12});
      build_model(N - 1);
      run(1'b0, ~64'h18, 40);
      cmp_model("bp");
      chk("bp_nbeat", ocyc.size(), 3);
      for (int k = 0; k < ocyc.size() && k < 3; k++) chk("bp_bcyc", ocyc[k], bpc[k]);

      // timeout: source 1 stalls mid-packet while source 2 waits
      do_reset();
      set(1, 1'b1, 8'h55, 1'b0);
      set(2, 1'b1, 8'h77, 1'b1);
      bus.m_axis_tready = 1'b1;
      step();
      chk("to_gid", 32'(grant_id), 1);
      step();
      set(1, 1'b0, 8'h00, 1'b0);
      chk("to_out55", 32'({bus.m_axis_tvalid, bus.m_axis_tdata}), 32'h155);
      for (int k = 0; k < 8; k++) begin
         chk("to_wait", 32'({grant_valid, timeout_pulse}), 32'b10);
         step();
      end
      chk("to_pulse", 32'({grant_valid, timeout_pulse}), 32'b01);
      step();
      chk("to_regrant", 32'({grant_valid, grant_id, timeout_pulse}), 32'b1_10_0);
      step();
      set(2, 1'b0, 8'h00, 1'b0);
      chk("to_out77", 32'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}), 32'h377);
      step();

      // timeout boundary: tvalid returns on the 8th idle cycle
      do_reset();
      set(1, 1'b1, 8'h55, 1'b0);
      step();
      step();
      set(1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 7; k++) step();
      set(1, 1'b1, 8'h56, 1'b1);
      step();
      set(1, 1'b0, 8'h00, 1'b0);
      chk("tob_pulse", 32'(timeout_pulse), 0);
      chk("tob_out", 32'({grant_valid, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}), 32'h356);
      step();
      chk("tob_pulse2", 32'(timeout_pulse), 0);

      // randomized traffic against the packet-level model
      for (int r = 0; r < 4; r++) begin
         do_reset();
         clear_src();
         for (int i = 0; i < N; i++) begin
            int npk;
            npk = int'($urandom_range(0, 3));
            for (int p = 0; p < npk; p++) begin
               int len;
               len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++) srcq[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         build_model(N - 1);
         run(1'b1, '0, 3000);
         cmp_model("rnd");
      end

      // reset mid-packet: output dropped, round robin restarts at source 0
      do_reset();
      clear_src();
      srcq[0].push_back({1'b1, 8'h99});
      run(1'b0, '1, 30);
      set(0, 1'b1, 8'hA0, 1'b0);
      bus.m_axis_tready = 1'b1;
      step();
      step();
      chk("mr_pre", 32'(bus.m_axis_tvalid), 1);
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      set(0, 1'b1, 8'hB0, 1'b1);
      set(1, 1'b1, 8'hC0, 1'b1);
      #1;
      chk_reset_vals("mr");
      step();
      chk("mr_gid", 32'(grant_id), 0);
      chk("mr_gvalid", 32'(grant_valid), 1);
      bus.s_axis_tvalid = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
